convolution_coprocessor_loop_counter: RTL and testbench
=======================================================

CONVOLUTION_COPROCESSOR_LOOP_COUNTER -- requirements
Module: convolution_coprocessor_loop_counter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, giving the width of each index and each limit.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start_i, input, 1, begins a loop sequence when sampled high in IDLE.
REQ-005 The block SHALL have port clr_i, input, 1, synchronous abort to IDLE with indices zeroed.
REQ-006 The block SHALL have port en_i, input, 1, advances the index pair by one step when high in RUN.
REQ-007 The block SHALL have port outer_max_i, input, DATA_WIDTH, last value of outer index i.
REQ-008 The block SHALL have port inner_max_i, input, DATA_WIDTH, last value of inner index j.
REQ-009 The block SHALL have port i_o, output, DATA_WIDTH, current outer index.
REQ-010 The block SHALL have port j_o, output, DATA_WIDTH, current inner index.
REQ-011 The block SHALL have port valid_o, output, 1, high while (i_o, j_o) is a live iteration (state RUN).
REQ-012 The block SHALL have port last_inner_o, output, 1, combinational: valid_o and j_o == latched inner max.
REQ-013 The block SHALL have port last_outer_o, output, 1, combinational: last_inner_o and i_o == latched outer max.
REQ-014 The block SHALL have port busy_o, output, 1, high in RUN and DONE.
REQ-015 The block SHALL have port done_o, output, 1, single-cycle pulse in state DONE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE.
REQ-017 In IDLE with start_i high, the block SHALL latch outer_max_i and inner_max_i, set i=0, j=0, and enter RUN next cycle.
REQ-018 Limit inputs SHALL be ignored outside that latch cycle; changes during RUN have no effect.
REQ-019 In RUN with en_i low, i, j and state SHALL hold.
REQ-020 In RUN with en_i high and j below inner max, j SHALL increment by 1 and i SHALL hold.
REQ-021 In RUN with en_i high and j equal to inner max and i below outer max, j SHALL become 0 and i SHALL increment by 1.
REQ-022 In RUN with en_i high and last_outer_o high, the block SHALL enter DONE; i and j SHALL hold their final values.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE; i_o/j_o keep final values in IDLE until next start or clr_i.
REQ-024 A full sequence SHALL produce exactly (outer_max+1)*(inner_max+1) cycles with valid_o and en_i both high.
REQ-025 Limits of 0 SHALL be legal; outer=inner=0 gives one iteration.
REQ-026 Limits of 2^DATA_WIDTH-1 SHALL be legal; terminal detection is by equality, so no index ever wraps or overflows.
REQ-027 start_i in RUN or DONE SHALL be ignored.
REQ-028 clr_i SHALL take priority over start_i and en_i in every state: next cycle IDLE, i=j=0, no done_o pulse.
REQ-029 start_i and clr_i high together in IDLE SHALL result in IDLE with i=j=0.

Reset
REQ-030 On rstn low, the block SHALL asynchronously enter IDLE with i_o=0, j_o=0, latched limits=0, valid_o=0, busy_o=0, done_o=0, last flags=0.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence with no done_o pulse; operation resumes only on a new start_i after rstn deasserts.

Structure
REQ-032 The FSM state enum and the default DATA_WIDTH constant SHALL live in shared package convolution_coprocessor_pkg.
REQ-033 Each index SHALL be built from one sub-module, convolution_coprocessor_index_stage (register with enable, synchronous clear-to-zero, +1 increment, terminal-count compare), instantiated twice.
REQ-034 The FSM and stage-chaining logic SHALL be in the top module; the design SHALL contain no latches or multi-clock logic.

Verification
REQ-035 Basic: outer=2, inner=3, start, en_i held high -> 12 valid cycles, (i,j) = (0,0),(0,1)..(0,3),(1,0)..(2,3); last_inner_o on j=3; last_outer_o on (2,3); done_o one pulse next cycle.
REQ-036 Stall: outer=1, inner=1, en_i toggled 1,0,0,1,1,0,1 -> indices hold on en_i=0; done_o after the 4th enabled step.
REQ-037 Boundary: outer=0, inner=0 -> one valid cycle at (0,0) with both last flags high, then done_o; DATA_WIDTH=3, both limits 7 -> 64 steps, ends at (7,7), no wrap.
REQ-038 Abort: clr_i at (1,2) of a 2x3 run -> next cycle IDLE, i=j=0, valid_o=0, no done_o; start_i mid-run -> no effect.
REQ-039 Reset: rstn low at (1,1) -> immediate zero outputs, IDLE; after release, start with outer=1, inner=0 -> 2 iterations then done_o.
REQ-040 Limit latch: change outer_max_i from 2 to 5 during RUN -> sequence still ends at i=2.

Source files
------------

// File: rtl/convolution_coprocessor_pkg.sv
// Shared types and constants for the convolution coprocessor loop counter.
package convolution_coprocessor_pkg;
  localparam int DATA_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/convolution_coprocessor_index_stage.sv
// One loop index: enabled +1 register with synchronous clear and terminal-count compare.
module convolution_coprocessor_index_stage
  import convolution_coprocessor_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr_i,
  input  logic                  inc_i,
  input  logic [DATA_WIDTH-1:0] max_i,
  output logic [DATA_WIDTH-1:0] idx_o,
  output logic                  tc_o
);
  logic [DATA_WIDTH-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)      idx_d = '0;
    else if (inc_i) idx_d = idx_q + DATA_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  assign idx_o = idx_q;
  // Equality compare keeps the index from ever stepping past its limit.
  assign tc_o  = (idx_q == max_i);
endmodule

// File: rtl/convolution_coprocessor_loop_counter.sv
// Two-level (i outer, j inner) loop index generator with start/enable/abort control.
module convolution_coprocessor_loop_counter
  import convolution_coprocessor_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] outer_max_i,
  input  logic [DATA_WIDTH-1:0] inner_max_i,
  output logic [DATA_WIDTH-1:0] i_o,
  output logic [DATA_WIDTH-1:0] j_o,
  output logic                  valid_o,
  output logic                  last_inner_o,
  output logic                  last_outer_o,
  output logic                  busy_o,
  output logic                  done_o
);
  state_e                state_q;
  logic [DATA_WIDTH-1:0] outer_max_q, inner_max_q;
  logic                  i_tc, j_tc;
  logic                  start_go, step;
  logic                  i_clr, i_inc, j_clr, j_inc;

  assign start_go = (state_q == ST_IDLE) && start_i && !clr_i;
  assign step     = (state_q == ST_RUN) && en_i && !clr_i;

  // Inner wraps to zero exactly when the outer index advances.
  assign j_inc = step && !j_tc;
  assign j_clr = clr_i || start_go || (step && j_tc && !i_tc);
  assign i_inc = step && j_tc && !i_tc;
  assign i_clr = clr_i || start_go;

  convolution_coprocessor_index_stage #(.DATA_WIDTH(DATA_WIDTH)) u_outer (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (i_clr),
    .inc_i (i_inc),
    .max_i (outer_max_q),
    .idx_o (i_o),
    .tc_o  (i_tc)
  );

  convolution_coprocessor_index_stage #(.DATA_WIDTH(DATA_WIDTH)) u_inner (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (j_clr),
    .inc_i (j_inc),
    .max_i (inner_max_q),
    .idx_o (j_o),
    .tc_o  (j_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      outer_max_q <= '0;
      inner_max_q <= '0;
    end else if (clr_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_q     <= ST_RUN;
          outer_max_q <= outer_max_i;
          inner_max_q <= inner_max_i;
        end
        ST_RUN:  if (en_i && j_tc && i_tc) state_q <= ST_DONE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_o      = (state_q == ST_RUN);
  assign busy_o       = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done_o       = (state_q == ST_DONE);
  assign last_inner_o = valid_o && j_tc;
  assign last_outer_o = last_inner_o && i_tc;
endmodule

// File: tb/tb_convolution_coprocessor_loop_counter.sv
// Randomized bench: expected (i,j) derived from the enabled-step count k as (k div (in+1), k mod (in+1)).
module tb_convolution_coprocessor_loop_counter;
  localparam int DW  = 6;
  localparam int DW3 = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start_i, clr_i, en_i;
  logic [DW-1:0] outer_max_i, inner_max_i, i_o, j_o;
  logic          valid_o, last_inner_o, last_outer_o, busy_o, done_o;

  logic           s3_start, s3_clr, s3_en;
  logic [DW3-1:0] s3_omax, s3_imax, s3_i, s3_j;
  logic           s3_valid, s3_li, s3_lo, s3_busy, s3_done;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  convolution_coprocessor_loop_counter #(.DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .clr_i(clr_i), .en_i(en_i),
    .outer_max_i(outer_max_i), .inner_max_i(inner_max_i), .i_o(i_o), .j_o(j_o),
    .valid_o(valid_o), .last_inner_o(last_inner_o), .last_outer_o(last_outer_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  convolution_coprocessor_loop_counter #(.DATA_WIDTH(DW3)) u_dut3 (
    .clk(clk), .rstn(rstn), .start_i(s3_start), .clr_i(s3_clr), .en_i(s3_en),
    .outer_max_i(s3_omax), .inner_max_i(s3_imax), .i_o(s3_i), .j_o(s3_j),
    .valid_o(s3_valid), .last_inner_o(s3_li), .last_outer_o(s3_lo),
    .busy_o(s3_busy), .done_o(s3_done)
  );

  // Status word order: valid, busy, done, last_inner, last_outer, i, j
  wire [4+2*DW:0] act = {valid_o, busy_o, done_o, last_inner_o, last_outer_o, i_o, j_o};

  // One full sequence; pat (if pat_len>0) gives en_i per cycle, else random with en_pct.
  task automatic run_seq(input int o, input int in, input int en_pct,
                         input logic [15:0] pat, input int pat_len,
                         input bit chg_lim, input string nm);
    int n, k, cyc;
    logic e;
    logic [4+2*DW:0] exp;
    n = (o + 1) * (in + 1); k = 0; cyc = 0;
    @(negedge clk);
    outer_max_i = DW'(o); inner_max_i = DW'(in); start_i = 1'b1; clr_i = 1'b0;
    en_i = 1'($urandom_range(1));
    @(negedge clk);
    start_i = 1'b0;
    while (k < n && cyc < 2000) begin
      exp = {1'b1, 1'b1, 1'b0, (k % (in + 1)) == in, k == n - 1,
             DW'(k / (in + 1)), DW'(k % (in + 1))};
      vectors++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s step k=%0d got %h want %h", nm, k, act, exp);
      end
      if (pat_len > 0) e = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else             e = ($urandom_range(99) < en_pct);
      en_i    = e;
      start_i = ($urandom_range(3) == 0);
      if (chg_lim) begin
        outer_max_i = DW'($urandom_range(63));
        inner_max_i = DW'($urandom_range(63));
      end
      @(negedge clk);
      cyc++;
      if (e) k++;
    end
    vectors++;
    if (k != n) begin
      errors++;
      $display("FAIL %s timeout steps got %0d want %0d", nm, k, n);
    end
    // start_i during DONE must be ignored
    start_i = 1'b1; en_i = 1'($urandom_range(1));
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DW'(o), DW'(in)};
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s done got %h want %h", nm, act, exp);
    end
    @(negedge clk);
    start_i = 1'b0; en_i = 1'b0;
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DW'(o), DW'(in)};
    for (int r = 0; r < 2; r++) begin
      vectors++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s idle_hold%0d got %h want %h", nm, r, act, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [4+2*DW:0] exp;
    rstn = 1'b0; start_i = 1'b0; clr_i = 1'b0; en_i = 1'b0;
    outer_max_i = '0; inner_max_i = '0;
    s3_start = 1'b0; s3_clr = 1'b0; s3_en = 1'b0; s3_omax = '0; s3_imax = '0;
    repeat (2) @(negedge clk);
    exp = '0;
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL reset_state got %h want %h", act, exp);
    end
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL reset_release got %h want %h", act, exp);
    end
  endtask

  task automatic test_basic();
    run_seq(2, 3, 100, 16'h0, 0, 1'b0, "basic_2x3");
  endtask

  task automatic test_stall();
    run_seq(1, 1, 0, 16'h0059, 7, 1'b0, "stall");
  endtask

  task automatic test_boundary();
    int k;
    logic [4+2*DW3:0] a3, e3;
    run_seq(0, 0, 100, 16'h0, 0, 1'b0, "single");
    run_seq(0, 0, 40, 16'h0, 0, 1'b0, "single_rand_en");
    @(negedge clk);
    s3_omax = 3'd7; s3_imax = 3'd7; s3_start = 1'b1;
    @(negedge clk);
    s3_start = 1'b0; s3_en = 1'b1; k = 0;
    while (k < 64) begin
      a3 = {s3_valid, s3_busy, s3_done, s3_li, s3_lo, s3_i, s3_j};
      e3 = {1'b1, 1'b1, 1'b0, (k % 8) == 7, k == 63, DW3'(k / 8), DW3'(k % 8)};
      vectors++;
      if (a3 !== e3) begin
        errors++;
        $display("FAIL wide_step k=%0d got %h want %h", k, a3, e3);
      end
      @(negedge clk);
      k++;
    end
    s3_en = 1'b0;
    a3 = {s3_valid, s3_busy, s3_done, s3_li, s3_lo, s3_i, s3_j};
    e3 = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 3'd7};
    vectors++;
    if (a3 !== e3) begin
      errors++;
      $display("FAIL wide_done got %h want %h", a3, e3);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [4+2*DW:0] exp;
    @(negedge clk);
    outer_max_i = 6'd2; inner_max_i = 6'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; en_i = 1'b1;
    repeat (6) @(negedge clk);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 6'd2};
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL abort_pos got %h want %h", act, exp);
    end
    clr_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0; start_i = 1'b0; en_i = 1'b0;
    exp = '0;
    for (int r = 0; r < 3; r++) begin
      vectors++;
      if (act !== exp) begin
        errors++;
        $display("FAIL abort_idle%0d got %h want %h", r, act, exp);
      end
      @(negedge clk);
    end
    // start and clear together in IDLE stay idle
    start_i = 1'b1; clr_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; clr_i = 1'b0;
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL start_clr_idle got %h want %h", act, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [4+2*DW:0] exp;
    @(negedge clk);
    outer_max_i = 6'd1; inner_max_i = 6'd1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; en_i = 1'b1;
    repeat (3) @(negedge clk);
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 6'd1};
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL rst_mid_pos got %h want %h", act, exp);
    end
    rstn = 1'b0;
    #1;
    exp = '0;
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL rst_async got %h want %h", act, exp);
    end
    @(negedge clk);
    rstn = 1'b1; en_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (act !== exp) begin
        errors++;
        $display("FAIL rst_no_done got %h want %h", act, exp);
      end
    end
    run_seq(1, 0, 100, 16'h0, 0, 1'b0, "rst_resume");
  endtask

  task automatic test_limit_latch();
    run_seq(2, 3, 70, 16'h0, 0, 1'b1, "limit_latch");
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++)
      run_seq(int'($urandom_range(4)), int'($urandom_range(4)),
              int'($urandom_range(30, 100)), 16'h0, 0, 1'($urandom_range(1)), "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_boundary();
    test_abort();
    test_reset_mid();
    test_limit_latch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
